apb_mem_slave: RTL and testbench



---
 rtl/apb_mem_slave.sv | 112 +++++++++++
 tb/tb_apb_mem_slave.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: byte-strobed read/write scratch memory with programmable
// access-phase wait states and an error response for misaligned or out-of-range addresses.
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    wr_en;
    logic                    ready;
    logic                    dec_err;
    logic [IDX_W-1:0]        dec_idx;

    assign dec_err = ((PADDR & LSB_MASK) != '0) || ((PADDR >> LSB) >= DEPTH_A);
    assign dec_idx = PADDR[LSB +: IDX_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        idx_d    = idx_q;
        prdata_d = prdata_q;
        wr_en    = 1'b0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACCESS;
                    cnt_d    = '0;
                    err_d    = dec_err;
                    idx_d    = dec_idx;
                    prdata_d = (!PWRITE && !dec_err) ? mem_q[dec_idx] : '0;
                end
            end
            ACCESS: begin
                ready = (cnt_q == CNT_MAX);
                // Losing PSEL mid-transfer abandons it without touching memory.
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    if (ready) begin
                        wr_en   = PWRITE && !err_q;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            prdata_q <= prdata_d;
            if (wr_en) begin
                for (int l = 0; l < LANES; l++) begin
                    if (PSTRB[l]) begin
                        mem_q[idx_q][8*l +: 8] <= PWDATA[8*l +: 8];
                    end
                end
            end
        end
    end

    assign PREADY  = ready;
    assign PRDATA  = prdata_q;
    assign PSLVERR = err_q & ready;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench: DUT 0 uses the default 2 wait states, DUT 1 is built with 0 wait states.
module tb_apb_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_mem_slave #(.WAIT_STATES(2)) u_ws2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Starts a setup phase right away (caller is just past a rising edge) and
    // returns just past the completion edge, so consecutive calls run back-to-back.
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] rd, output logic err, output int cyc);
        bit done;
        done = 0; cyc = 0; rd = '0; err = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = w;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = s;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        while (!done && cyc < 20) begin
            cyc++;
            @(negedge clk);
            if (pready[d]) begin
                rd = prdata[d]; err = pslverr[d]; done = 1;
            end else begin
                check("slverr_while_waiting", {31'd0, pslverr[d]}, 32'd0);
            end
            @(posedge clk); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (!done) check("pready_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_pready",  {31'd0, pready[0]},  32'd0);
        check("reset_prdata",  prdata[0],           32'd0);
        check("reset_pslverr", {31'd0, pslverr[0]}, 32'd0);
        @(posedge clk); #1;

        // Full-word write/read with 2 wait states
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        check("wr10_cycles", cyc, 3);
        check("wr10_err", {31'd0, er}, 32'd0);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("rd10_cycles", cyc, 3);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_err", {31'd0, er}, 32'd0);

        // Byte strobes
        xfer(0, 1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc);
        xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
        xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
        check("strobe_merge", rd, 32'h11BB33DD);

        // Out-of-range write aliases word 0 by index bits but must not land
        xfer(0, 1, 32'h400, 32'h55555555, 4'hF, rd, er, cyc);
        check("wr400_err", {31'd0, er}, 32'd1);
        check("wr400_cycles", cyc, 3);
        xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
        check("rd0_unchanged", rd, 32'h0);
        check("rd0_err", {31'd0, er}, 32'd0);
        xfer(0, 0, 32'h13, 32'h0, 4'h0, rd, er, cyc);
        check("rd13_err", {31'd0, er}, 32'd1);
        check("rd13_data", rd, 32'h0);

        // Zero-strobe write is a clean no-op
        xfer(0, 1, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("strb0_err", {31'd0, er}, 32'd0);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("strb0_keep", rd, 32'hDEADBEEF);

        // Zero wait states, back-to-back
        xfer(1, 1, 32'h4, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        check("ws0_wr_cycles", cyc, 1);
        xfer(1, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
        check("ws0_rd_cycles", cyc, 1);
        check("ws0_rd_data", rd, 32'hCAFEF00D);

        xfer(0, 1, 32'h8, 32'h12345678, 4'hF, rd, er, cyc);
        xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
        check("rd8_before_reset", rd, 32'h12345678);

        // Reset while PREADY is high drops it without a clock edge
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h14;
        pwdata[0] = 32'h9; pstrb[0] = 4'hF;
        @(posedge clk); #1 penable[0] = 1;
        repeat (2) @(posedge clk);
        #1 check("ready_before_async_rst", {31'd0, pready[0]}, 32'd1);
        rst = 1'b1;
        #1 check("ready_async_drop", {31'd0, pready[0]}, 32'd0);
        psel[0] = 0; penable[0] = 0;
        @(posedge clk); #1 rst = 1'b0;

        // Reset during the 2nd access cycle of a write to 0x8
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h8;
        pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
        @(posedge clk); #1 penable[0] = 1;
        @(posedge clk); #1 rst = 1'b1;
        #1 check("midrst_pready", {31'd0, pready[0]}, 32'd0);
        psel[0] = 0; penable[0] = 0;
        @(posedge clk); #1 rst = 1'b0;
        xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
        check("rd8_after_reset", rd, 32'h0);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("rd10_after_reset", rd, 32'h0);

        // PSEL abandoned during ACCESS with a write pending
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'hC;
        pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
        @(posedge clk); #1 penable[0] = 1;
        @(posedge clk); #1 psel[0] = 0; penable[0] = 0;
        @(negedge clk);
        check("drop_pready", {31'd0, pready[0]}, 32'd0);
        @(posedge clk); #1;
        xfer(0, 0, 32'hC, 32'h0, 4'h0, rd, er, cyc);
        check("drop_rd_cycles", cyc, 3);
        check("drop_rd_data", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
